// File: rtl/flopenr_arb_pkg.sv
// Shared definitions for the flopenr round-robin arbiter.
//   - arb_state_e : lock FSM states (only used when FLOPENR_ARB_LOCK_EN is set)
//   - DEF_*       : default parameter values for the arbiter
//   - rr_pick     : round-robin priority search, returns a one-hot grant
package flopenr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_LOCK = 8;

  // Scan indices ptr+1, ptr+2, ... modulo n and grant the first requester
  // found. The requester at ptr itself is checked last, so a requester that
  // was just served only wins again when nobody else is asking.
  function automatic logic [15:0] rr_pick(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input int unsigned n);
    logic [15:0] g;
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= 16; off++) begin
      if (off <= n && !found) begin
        idx = (32'(ptr) + off) % n;
        if (req[idx[3:0]]) begin
          g[idx[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/flopenr_arbiter_flopenr.sv
// flopenr: single-bit enabled register with asynchronous active-high reset.
// Ports:
//   clk : clock, rising edge
//   r   : asynchronous reset, active-high, clears q
//   en  : load enable
//   d   : data in
//   q   : stored value
module flopenr (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flopenr_arbiter.sv
// flopenr_arbiter: round-robin arbiter sharing one W-bit flopenr-based
// register among N requesters. At most one requester is granted per cycle;
// the grant drives the register enable and the write-data mux.
// Optional feature macro: FLOPENR_ARB_LOCK_EN adds the lock port and an
// IDLE/LOCKED FSM that lets the winner hold the register for up to MAX_LOCK
// consecutive writes.
// Ports:
//   clk   : clock, rising edge
//   r     : asynchronous reset, active-high
//   req   : [N] write requests
//   wd    : [N][W] per-requester write data
//   lock  : [N] grant-hold requests (FLOPENR_ARB_LOCK_EN only)
//   gnt   : [N] one-hot or zero grant, combinational, forced 0 during reset
//   q     : [W] shared register value
//   valid : register written since reset
//   owner : index of the last requester written
module flopenr_arbiter
  import flopenr_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic [N-1:0]            req,
  input  logic [N-1:0][W-1:0]     wd,
`ifdef FLOPENR_ARB_LOCK_EN
  input  logic [N-1:0]            lock,
`endif
  output logic [N-1:0]            gnt,
  output logic [W-1:0]            q,
  output logic                    valid,
  output logic [$clog2(N)-1:0]    owner
);

  localparam int OW = $clog2(N);

  logic [OW-1:0] ptr_q,   ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          valid_q, valid_d;

  logic [15:0]   req16;
  logic [3:0]    ptr4;
  logic [15:0]   rr_gnt;
  logic [N-1:0]  gnt_c;
  logic [OW-1:0] win_idx;
  logic          wr_en;
  logic [W-1:0]  wr_data;

  // Widen to the fixed width used by the package search function.
  always_comb begin
    req16        = '0;
    req16[N-1:0] = req;
    ptr4         = '0;
    ptr4[OW-1:0] = ptr_q;
  end

  assign rr_gnt = rr_pick(req16, ptr4, N);

`ifdef FLOPENR_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // While locked, only the recorded owner may write; everyone else is masked.
  always_comb begin
    gnt_c = rr_gnt[N-1:0];
    if (state_q == LOCKED) begin
      gnt_c          = '0;
      gnt_c[owner_q] = req[owner_q];
    end
  end
`else
  assign gnt_c = rr_gnt[N-1:0];
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_c[i]) win_idx = OW'(i);
    end
  end

  // Reset masks the grant asynchronously so nothing is enabled while r is high.
  assign gnt     = r ? '0 : gnt_c;
  assign wr_en   = |gnt;
  assign wr_data = wd[win_idx];

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    valid_d = valid_q;
    if (wr_en) begin
      ptr_d   = win_idx;
      owner_d = win_idx;
      valid_d = 1'b1;
    end
  end

`ifdef FLOPENR_ARB_LOCK_EN
  // The write that enters LOCKED counts as the first locked write. Leaving
  // LOCKED keeps ptr at the owner, so round-robin moves on to someone else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_en && lock[win_idx] && (MAX_LOCK > 1)) begin
          state_d = LOCKED;
          cnt_d   = CW'(1);
        end
      end
      LOCKED: begin
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d >= CW'(MAX_LOCK)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  // ptr resets to N-1 so requester 0 is first in line after reset.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      ptr_q   <= OW'(N - 1);
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_bit
    flopenr u_ff (
      .clk (clk),
      .r   (r),
      .en  (wr_en),
      .d   (wr_data[b]),
      .q   (q[b])
    );
  end

  assign valid = valid_q;
  assign owner = owner_q;

endmodule
